// File: rtl/rtc_bus_pkg.sv
// -----------------------------------------------------------------------------
// rtc_bus_pkg
// Shared definitions for the RTC bus sequencer:
//   - estado_t             : sequencer FSM states
//   - T_FASE_DEF/N_REG_DEF : default phase width and maximum burst length
//   - RTC_DIR_TRANSFER     : command address of the trailing transfer transaction
//   - RTC register map     : time block 8'h21-8'h26, chrono block 8'h41-8'h43
//   - es_fase_temporizada  : true for the states timed by the phase counter
// -----------------------------------------------------------------------------
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        INACT = 3'd0,
        DIR   = 3'd1,
        ESP1  = 3'd2,
        DATO  = 3'd3,
        ESP2  = 3'd4,
        FIN   = 3'd5
    } estado_t;

    localparam int T_FASE_DEF = 4;
    localparam int N_REG_DEF  = 9;

    localparam logic [7:0] RTC_DIR_TRANSFER = 8'hF1;

    // Time registers
    localparam logic [7:0] RTC_SEG  = 8'h21;
    localparam logic [7:0] RTC_MIN  = 8'h22;
    localparam logic [7:0] RTC_HORA = 8'h23;
    localparam logic [7:0] RTC_DIA  = 8'h24;
    localparam logic [7:0] RTC_MES  = 8'h25;
    localparam logic [7:0] RTC_ANIO = 8'h26;

    // Chronometer registers
    localparam logic [7:0] RTC_CRONO_CENT = 8'h41;
    localparam logic [7:0] RTC_CRONO_SEG  = 8'h42;
    localparam logic [7:0] RTC_CRONO_MIN  = 8'h43;

    function automatic logic es_fase_temporizada(input estado_t e);
        return (e == DIR) || (e == ESP1) || (e == DATO) || (e == ESP2);
    endfunction

endpackage

// File: rtl/rtc_fase_cont.sv
// -----------------------------------------------------------------------------
// rtc_fase_cont
// Phase-width down-counter. Loading sets the count to T_FASE-1; it then counts
// down to zero and holds there. A phase lasts exactly T_FASE cycles when the
// counter is loaded on the edge that enters it.
// Ports:
//   reloj_i   : clock
//   reset_i   : synchronous active-high reset
//   carga_i   : load T_FASE-1 on this edge (a new phase starts next cycle)
//   fin_o     : current cycle is the last one of the phase
//   fin_sig_o : next cycle will be the last one of the phase (after this edge)
// -----------------------------------------------------------------------------
module rtc_fase_cont #(
    parameter int T_FASE = 4
) (
    input  logic reloj_i,
    input  logic reset_i,
    input  logic carga_i,
    output logic fin_o,
    output logic fin_sig_o
);

    localparam int CW = (T_FASE > 1) ? $clog2(T_FASE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (carga_i) begin
            cnt_d = CW'(T_FASE - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge reloj_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fin_o     = (cnt_q == '0);
    assign fin_sig_o = (cnt_d == '0);

endmodule

// File: rtl/rtc_bus_secuenciador.sv
// -----------------------------------------------------------------------------
// rtc_bus_secuenciador
// Burst engine for the multiplexed address/data RTC bus. One request moves
// 1..N_REG consecutive registers; each register takes four phases of T_FASE
// cycles: DIR (address), ESP1 (turnaround), DATO (data), ESP2 (turnaround).
// All outputs are registered: they are decoded from the next state and loaded
// on the same edge as the state register.
//
// Optional feature (macro RTC_SEC_TRANSFER_EN): after the last register of a
// write burst, one address-only DIR+ESP1 transaction to DIR_TRANSFER is issued
// before done. Undefined by default.
//
// Ports:
//   reloj, resetM             : clock, synchronous active-high reset
//   req, escribir, dir_base,
//   cantidad                  : burst request (sampled while not busy)
//   busy, done                : burst in progress / one-cycle end pulse
//   wr_pide, wr_idx, wr_dato  : write-data request; data sampled next edge
//   rd_valido, rd_idx, rd_dato: read-data strobe with index and value
//   cs_n, rd_n, wr_n, a_d     : RTC strobes (active-low) and phase select
//   bus_out, bus_oe, bus_in   : pad driver interface
// -----------------------------------------------------------------------------
module rtc_bus_secuenciador
    import rtc_bus_pkg::*;
#(
    parameter int               N_REG        = N_REG_DEF,
    parameter int               T_FASE       = T_FASE_DEF,
    parameter int               ANCHO        = 8,
    parameter logic [ANCHO-1:0] DIR_TRANSFER = ANCHO'(RTC_DIR_TRANSFER),
    localparam int              CW           = $clog2(N_REG + 1),
    localparam int              IW           = $clog2(N_REG)
) (
    input  logic             reloj,
    input  logic             resetM,
    input  logic             req,
    input  logic             escribir,
    input  logic [ANCHO-1:0] dir_base,
    input  logic [CW-1:0]    cantidad,
    output logic             busy,
    output logic             done,
    output logic             wr_pide,
    output logic [IW-1:0]    wr_idx,
    input  logic [ANCHO-1:0] wr_dato,
    output logic             rd_valido,
    output logic [IW-1:0]    rd_idx,
    output logic [ANCHO-1:0] rd_dato,
    output logic             cs_n,
    output logic             rd_n,
    output logic             wr_n,
    output logic             a_d,
    output logic [ANCHO-1:0] bus_out,
    output logic             bus_oe,
    input  logic [ANCHO-1:0] bus_in
);

    // ---------------------------------------------------------------- control
    estado_t          estado_q, estado_d;
    logic             escr_q, escr_d;
    logic [ANCHO-1:0] dir_q, dir_d;
    logic [CW-1:0]    cant_q, cant_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             transf_q, transf_d;   // in the trailing transfer transaction

    // ---------------------------------------------------------------- outputs
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_pide_q, wr_pide_d;
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic             rd_valido_q, rd_valido_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [ANCHO-1:0] rd_dato_q, rd_dato_d;
    logic             cs_n_q, cs_n_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;
    logic             a_d_q, a_d_d;
    logic [ANCHO-1:0] bus_out_q, bus_out_d;
    logic             bus_oe_q, bus_oe_d;

    logic          fase_fin;      // current cycle is the last of its phase
    logic          fase_fin_sig;  // next cycle is the last of its phase
    logic          fase_carga;
    logic          ultimo;        // current register is the last of the burst
    logic [CW-1:0] cant_recortada;

    // A phase starts whenever the FSM moves into a timed state.
    assign fase_carga = es_fase_temporizada(estado_d) && (estado_d != estado_q);

    rtc_fase_cont #(
        .T_FASE (T_FASE)
    ) u_fase_cont (
        .reloj_i   (reloj),
        .reset_i   (resetM),
        .carga_i   (fase_carga),
        .fin_o     (fase_fin),
        .fin_sig_o (fase_fin_sig)
    );

    assign cant_recortada = (cantidad > CW'(N_REG)) ? CW'(N_REG) : cantidad;
    assign ultimo         = ((CW'(idx_q) + CW'(1)) == cant_q);

    // ------------------------------------------------------ next-state logic
    always_comb begin
        estado_d = estado_q;
        escr_d   = escr_q;
        dir_d    = dir_q;
        cant_d   = cant_q;
        idx_d    = idx_q;
        transf_d = transf_q;

        unique case (estado_q)
            INACT, FIN: begin
                // FIN also accepts a request so bursts can run back to back.
                estado_d = INACT;
                if (req) begin
                    escr_d   = escribir;
                    dir_d    = dir_base;
                    cant_d   = cant_recortada;
                    idx_d    = '0;
                    transf_d = 1'b0;
                    estado_d = (cantidad == '0) ? FIN : DIR;
                end
            end
            DIR: begin
                if (fase_fin) estado_d = ESP1;
            end
            ESP1: begin
                if (fase_fin) estado_d = transf_q ? FIN : DATO;
            end
            DATO: begin
                if (fase_fin) estado_d = ESP2;
            end
            ESP2: begin
                if (fase_fin) begin
                    dir_d = dir_q + ANCHO'(1);
                    idx_d = idx_q + IW'(1);
                    if (!ultimo) begin
                        estado_d = DIR;
                    end else begin
`ifdef RTC_SEC_TRANSFER_EN
                        if (escr_q) begin
                            dir_d    = DIR_TRANSFER;
                            transf_d = 1'b1;
                            estado_d = DIR;
                        end else begin
                            estado_d = FIN;
                        end
`else
                        estado_d = FIN;
`endif
                    end
                end
            end
            default: estado_d = INACT;
        endcase
    end

    // --------------------------------------- output decode from the next state
    always_comb begin
        busy_d      = 1'b0;
        done_d      = 1'b0;
        wr_pide_d   = 1'b0;
        wr_idx_d    = idx_d;
        rd_valido_d = 1'b0;
        rd_idx_d    = rd_idx_q;
        rd_dato_d   = rd_dato_q;
        cs_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        a_d_d       = 1'b1;
        bus_out_d   = bus_out_q;
        bus_oe_d    = 1'b0;

        unique case (estado_d)
            DIR: begin
                busy_d    = 1'b1;
                cs_n_d    = 1'b0;
                wr_n_d    = 1'b0;
                a_d_d     = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = dir_d;
            end
            ESP1: begin
                busy_d    = 1'b1;
                wr_pide_d = escr_d && !transf_d && fase_fin_sig;
            end
            DATO: begin
                busy_d = 1'b1;
                cs_n_d = 1'b0;
                if (escr_d) begin
                    wr_n_d   = 1'b0;
                    bus_oe_d = 1'b1;
                    // Write data is sampled once, on the edge after wr_pide.
                    if (estado_q != DATO) bus_out_d = wr_dato;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            ESP2: begin
                busy_d = 1'b1;
                // The edge leaving DATO captures the pad and publishes it.
                if ((estado_q == DATO) && !escr_q) begin
                    rd_valido_d = 1'b1;
                    rd_dato_d   = bus_in;
                    rd_idx_d    = idx_q;
                end
            end
            FIN: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge reloj) begin
        if (resetM) begin
            estado_q    <= INACT;
            escr_q      <= 1'b0;
            dir_q       <= '0;
            cant_q      <= '0;
            idx_q       <= '0;
            transf_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_pide_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_valido_q <= 1'b0;
            rd_idx_q    <= '0;
            rd_dato_q   <= '0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a_d_q       <= 1'b1;
            bus_out_q   <= '0;
            bus_oe_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            escr_q      <= escr_d;
            dir_q       <= dir_d;
            cant_q      <= cant_d;
            idx_q       <= idx_d;
            transf_q    <= transf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_pide_q   <= wr_pide_d;
            wr_idx_q    <= wr_idx_d;
            rd_valido_q <= rd_valido_d;
            rd_idx_q    <= rd_idx_d;
            rd_dato_q   <= rd_dato_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            a_d_q       <= a_d_d;
            bus_out_q   <= bus_out_d;
            bus_oe_q    <= bus_oe_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_pide   = wr_pide_q;
    assign wr_idx    = wr_idx_q;
    assign rd_valido = rd_valido_q;
    assign rd_idx    = rd_idx_q;
    assign rd_dato   = rd_dato_q;
    assign cs_n      = cs_n_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign a_d       = a_d_q;
    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;

endmodule

// File: tb/tb_rtc_bus_secuenciador.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_secuenciador
// Scoreboard bench for rtc_bus_secuenciador (T_FASE=4, N_REG=9). Each issued
// burst pushes its expected bus events (address, write data, read data, done
// cycle) into a queue; a forked monitor pops and compares whenever the DUT
// shows an event. Cycle numbering: after edge k the bench counter equals k and
// that period is cycle k+1.
// -----------------------------------------------------------------------------
module tb_rtc_bus_secuenciador;

    localparam int T = 4;

`ifdef RTC_SEC_TRANSFER_EN
    localparam bit CON_TRANSF   = 1'b1;
    localparam int EXTRA_TRANSF = 2 * T;
`else
    localparam bit CON_TRANSF   = 1'b0;
    localparam int EXTRA_TRANSF = 0;
`endif

    logic       reloj = 1'b0;
    logic       resetM = 1'b1;
    logic       req = 1'b0;
    logic       escribir = 1'b0;
    logic [7:0] dir_base = 8'h00;
    logic [3:0] cantidad = 4'd0;
    logic       busy, done, wr_pide, rd_valido;
    logic [3:0] wr_idx, rd_idx;
    logic [7:0] wr_dato = 8'h00;
    logic [7:0] rd_dato, bus_out, bus_in;
    logic       cs_n, rd_n, wr_n, a_d, bus_oe;
    logic [7:0] rtc_dir = 8'h00;

    rtc_bus_secuenciador dut (
        .reloj     (reloj),
        .resetM    (resetM),
        .req       (req),
        .escribir  (escribir),
        .dir_base  (dir_base),
        .cantidad  (cantidad),
        .busy      (busy),
        .done      (done),
        .wr_pide   (wr_pide),
        .wr_idx    (wr_idx),
        .wr_dato   (wr_dato),
        .rd_valido (rd_valido),
        .rd_idx    (rd_idx),
        .rd_dato   (rd_dato),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .a_d       (a_d),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .bus_in    (bus_in)
    );

    always #5 reloj = ~reloj;

    int cyc = 0;
    always @(posedge reloj) cyc <= cyc + 1;

    // Data source and RTC model: write data follows the requested index,
    // the RTC returns the last latched address inverted.
    always @(negedge reloj) begin
        if (wr_pide) wr_dato <= 8'h10 + {4'h0, wr_idx};
        if (!cs_n && !a_d) rtc_dir <= bus_out;
    end
    assign bus_in = rtc_dir ^ 8'hFF;

    typedef enum int {EV_DIR, EV_WDAT, EV_RD, EV_DONE} ev_t;
    typedef struct {
        ev_t tipo;
        int  valor;
        int  idx;
    } ev_s;

    ev_s esperado[$];
    int  checks = 0;
    int  errors = 0;
    int  cs_bajos = 0;

    task automatic check(input string nombre, input int actual, input int requerido);
        checks++;
        if (actual !== requerido) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nombre, actual, requerido, cyc + 1);
        end
    endtask

    task automatic push(input ev_t t, input int v, input int ix);
        ev_s e;
        e.tipo  = t;
        e.valor = v;
        e.idx   = ix;
        esperado.push_back(e);
    endtask

    task automatic observa(input ev_t t, input int v, input int ix);
        ev_s e;
        if (esperado.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got %0h expected no event (cycle %0d)", t.name(), v, cyc + 1);
        end else begin
            e = esperado.pop_front();
            check($sformatf("kind_%s", e.tipo.name()), int'(t), int'(e.tipo));
            check($sformatf("value_%s", e.tipo.name()), v, e.valor);
            if (t == EV_RD) check("rd_idx", ix, e.idx);
        end
    endtask

    task automatic monitor();
        bit prev_dir = 1'b0;
        bit prev_wdat = 1'b0;
        forever begin
            @(negedge reloj);
            if (resetM) begin
                prev_dir  = 1'b0;
                prev_wdat = 1'b0;
            end else begin
                if (!cs_n && !a_d && !prev_dir)            observa(EV_DIR, int'(bus_out), 0);
                if (!cs_n && !wr_n && a_d && !prev_wdat)   observa(EV_WDAT, int'(bus_out), 0);
                if (rd_valido)                             observa(EV_RD, int'(rd_dato), int'(rd_idx));
                if (done)                                  observa(EV_DONE, cyc + 1, 0);
                if (!cs_n && !rd_n && bus_oe)              check("read_oe_off", 1, 0);
                prev_dir  = !cs_n && !a_d;
                prev_wdat = !cs_n && !wr_n && a_d;
                if (!cs_n) cs_bajos++;
            end
        end
    endtask

    // Issue a burst at a negedge; off is the hand-computed done cycle minus k.
    task automatic lanza(input bit esc, input logic [7:0] base, input logic [3:0] cant, input int off);
        int n;
        int k;
        n = (cant > 4'd9) ? 9 : int'(cant);
        k = cyc + 1;
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            push(EV_DIR, int'(a), 0);
            if (esc) push(EV_WDAT, 16 + i, 0);
            else     push(EV_RD, int'(a ^ 8'hFF), i);
        end
        if (esc && n > 0 && CON_TRANSF) begin
            push(EV_DIR, 'hF1, 0);
            off = off + EXTRA_TRANSF;
        end
        push(EV_DONE, k + off, 0);
        escribir = esc;
        dir_base = base;
        cantidad = cant;
        req      = 1'b1;
        @(negedge reloj);
        req      = 1'b0;
    endtask

    task automatic espera_done(input int max);
        int n = 0;
        while (!done && n < max) begin
            @(negedge reloj);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        int snap;
        bit visto_done;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge reloj);
        check("rst_cs_n", cs_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_a_d", a_d, 1);
        check("rst_bus_oe", bus_oe, 0);
        check("rst_bus_out", bus_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_pide", wr_pide, 0);
        check("rst_rd_valido", rd_valido, 0);
        check("rst_rd_dato", rd_dato, 0);
        check("rst_idx", {rd_idx, wr_idx}, 0);
        resetM = 1'b0;
        repeat (2) @(negedge reloj);

        // Write burst 21/22/23 with data 10/11/12, done at k+49
        lanza(1'b1, 8'h21, 4'd3, 49);
        espera_done(200);
        repeat (2) @(negedge reloj);

        // Read burst 41..43 -> BE/BD/BC, then a request in the FIN cycle
        lanza(1'b0, 8'h41, 4'd3, 49);
        espera_done(200);
        lanza(1'b0, 8'h24, 4'd1, 17);
        check("fin_accept_busy", busy, 1);
        espera_done(100);
        repeat (2) @(negedge reloj);

        // cantidad = 0: done at k+1, no strobes
        snap = cs_bajos;
        lanza(1'b1, 8'h30, 4'd0, 1);
        espera_done(5);
        repeat (3) @(negedge reloj);
        check("cnt0_no_strobe", cs_bajos - snap, 0);

        // cantidad = 12 clipped to 9 registers, done at k+1+16*9
        lanza(1'b0, 8'h21, 4'd12, 145);
        espera_done(300);
        repeat (2) @(negedge reloj);

        // Address wrap FE, FF, 00 with a request during register 1
        lanza(1'b1, 8'hFE, 4'd3, 49);
        repeat (18) @(negedge reloj);
        escribir = 1'b0;
        dir_base = 8'h80;
        cantidad = 4'd2;
        req      = 1'b1;
        @(negedge reloj);
        req      = 1'b0;
        check("busy_during_ignored_req", busy, 1);
        espera_done(200);
        repeat (4) @(negedge reloj);
        check("ignored_req_not_queued", busy, 0);

        // Reset in the DATO phase of a write
        push(EV_DIR, 'h21, 0);
        push(EV_WDAT, 'h10, 0);
        escribir = 1'b1;
        dir_base = 8'h21;
        cantidad = 4'd3;
        req      = 1'b1;
        @(negedge reloj);
        req      = 1'b0;
        for (int w = 0; w < 30 && !(!cs_n && !wr_n && a_d); w++) @(negedge reloj);
        check("reached_write_dato", int'(!cs_n && !wr_n && a_d), 1);
        @(negedge reloj);
        resetM = 1'b1;
        @(negedge reloj);
        check("rst_mid_strobes", {cs_n, rd_n, wr_n}, 3'b111);
        check("rst_mid_bus_oe", bus_oe, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        resetM = 1'b0;
        visto_done = 1'b0;
        repeat (10) begin
            @(negedge reloj);
            if (done) visto_done = 1'b1;
        end
        check("rst_mid_no_done", visto_done, 0);

        // Drain: anything still expected is a missed event
        for (int w = 0; w < 50 && esperado.size() != 0; w++) @(negedge reloj);
        while (esperado.size() != 0) begin
            ev_s e;
            e = esperado.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_%s: got nothing expected %0h", e.tipo.name(), e.valor);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
